message_sink_buffer: RTL

MESSAGE_SINK_BUFFER -- requirements
Module: message_sink_buffer

---
 rtl/des_reduced.sv | 16 +
 rtl/message_fifo.sv | 63 ++++++
 rtl/message_sink_buffer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/des_reduced.sv
// Shared constants and state encoding for the message sink buffer.
// Imported by the top and its FIFO.
package des_reduced;

  localparam int N_DEF     = 32;
  localparam int DEPTH_DEF = 8;
  localparam int PAUSE_OFS = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECEIVE,
    S_DRAIN,
    S_DONE
  } state_e;

endpackage

// File: rtl/message_fifo.sv
// Power-of-two FIFO with extra-bit pointers and flush.
// Head reads as zero while empty so out_data is clean.
module message_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count   = wr_q - rd_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem_q[rd_q[AW-1:0]];

  // pointer next-state; flush wins over traffic
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
    end
  end

  // pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // storage write
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/message_sink_buffer.sv
// Sink for counter-generator messages: buffers, checks
// sequence/region, applies back-pressure, tracks drain.
module message_sink_buffer
  import des_reduced::*;
#(
  parameter int N     = N_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [63:0]   msg,
  input  logic          msg_valid,
  input  logic          gen_done,
  input  logic          clear,
  input  logic [N-1:0]  region_expect,
  output logic          pause,
  output logic [63:0]   out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [64-N:0] msg_count,
  output logic          seq_error,
  output logic          overflow,
  output logic          drained
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = 65 - N;
  localparam int EW = 64 - N;
  localparam logic [AW:0] PTH = (AW+1)'(DEPTH - PAUSE_OFS);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [EW-1:0]   exp_q, exp_d;
  logic            err_q, err_d;
  logic            ovf_q, ovf_d;
  logic            push_req;
  logic            pop;
  logic            accept;
  logic            drop;
  logic            next_empty;
  logic            f_empty;
  logic            f_full;
  logic [AW:0]     f_count;

  assign push_req   = msg_valid && !clear &&
                      (state_q == S_IDLE ||
                       state_q == S_RECEIVE);
  assign pop        = !f_empty && out_ready;
  assign accept     = push_req && (!f_full || pop);
  assign drop       = push_req && f_full && !pop;
  assign next_empty = f_empty || (f_count == ONE && pop);

  message_fifo #(
    .WIDTH (64),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (clear),
    .push  (push_req),
    .pop   (pop),
    .din   (msg),
    .dout  (out_data),
    .empty (f_empty),
    .full  (f_full),
    .count (f_count)
  );

  assign pause     = (f_count >= PTH);
  assign out_valid = !f_empty;
  assign drained   = (state_q == S_DONE);
  assign msg_count = cnt_q;
  assign seq_error = err_q;
  assign overflow  = ovf_q;

  // state transitions; clear overrides everything
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (msg_valid)  state_d = S_RECEIVE;
      S_RECEIVE: if (gen_done)   state_d = S_DRAIN;
      S_DRAIN:   if (next_empty) state_d = S_DONE;
      S_DONE:    state_d = S_DONE;
    endcase
    if (clear) state_d = S_IDLE;
  end

  // counting, sequence check and sticky flags
  always_comb begin
    cnt_d = cnt_q;
    exp_d = exp_q;
    err_d = err_q;
    ovf_d = ovf_q;
    if (clear) begin
      cnt_d = '0;
      exp_d = '0;
      err_d = 1'b0;
      ovf_d = 1'b0;
    end else begin
      if (drop) ovf_d = 1'b1;
      if (accept) begin
        if (cnt_q != {CW{1'b1}}) cnt_d = cnt_q + 1'b1;
        if (msg[N-1:0] != region_expect ||
            msg[63:N] != exp_q)
          err_d = 1'b1;
        exp_d = msg[63:N] + 1'b1;
      end
    end
  end

  // control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      exp_q   <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
